btb_bht_predictor: RTL and testbench

- Parametrised branch target buffer with a gshare branch history table, on the fetch stage beside the instruction cache.
- Each request covers one aligned fetch block of FETCH_WIDTH 32-bit instructions.
- Returns a registered prediction: taken, lane mask, branch lane index, target, opaque entry id, history and counter value.
- Trained by a single update port from execute; supports full invalidate on fence.i.

---
 rtl/btb_bht_predictor.sv | 191 +++++++++++++++++++
 tb/tb_btb_bht_predictor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_bht_predictor.sv
// rtl/btb_bht_predictor.sv - fully-associative BTB with gshare BHT for fetch-block prediction
module btb_bht_predictor #(
   parameter int FETCH_WIDTH = 4,
   parameter int ENTRIES     = 8,
   parameter int BHT_ENTRIES = 64,
   parameter int HIST_BITS   = 6,
   localparam int OFF   = $clog2(FETCH_WIDTH),
   localparam int IDX   = $clog2(ENTRIES),
   localparam int BI    = $clog2(BHT_ENTRIES),
   localparam int TAG_W = 32 - OFF - 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic [31:0]            req_addr,
   output logic                   resp_valid,
   output logic                   resp_hit,
   output logic                   resp_taken,
   output logic [FETCH_WIDTH-1:0] resp_mask,
   output logic [OFF-1:0]         resp_bridx,
   output logic [31:0]            resp_target,
   output logic [IDX-1:0]         resp_entry,
   output logic [HIST_BITS-1:0]   resp_history,
   output logic [1:0]             resp_counter,
   input  logic                   upd_valid,
   input  logic [31:0]            upd_pc,
   input  logic [31:0]            upd_target,
   input  logic                   upd_taken,
   input  logic                   upd_is_jump,
   input  logic [HIST_BITS-1:0]   upd_history,
   input  logic                   invalidate
);

   // BTB entry storage; only the valid bits need a reset value
   logic [ENTRIES-1:0] e_valid;
   logic [TAG_W-1:0]   e_tag    [ENTRIES];
   logic [OFF-1:0]     e_bridx  [ENTRIES];
   logic [31:0]        e_target [ENTRIES];
   logic [ENTRIES-1:0] e_jump;
   logic [IDX-1:0]     alloc_ptr;

   // Direction state
   logic [1:0]           bht [BHT_ENTRIES];
   logic [HIST_BITS-1:0] ghr;

   logic [TAG_W-1:0] req_blk;
   logic [OFF-1:0]   req_lane;
   logic [TAG_W-1:0] upd_blk;
   logic [OFF-1:0]   upd_lane;

   assign req_blk  = req_addr[31:OFF+2];
   assign req_lane = req_addr[OFF+1:2];
   assign upd_blk  = upd_pc[31:OFF+2];
   assign upd_lane = upd_pc[OFF+1:2];

   // Byte-offset bits never matter: instructions are word aligned
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[1:0], upd_pc[1:0]};

   logic                   lk_hit;
   logic [IDX-1:0]         lk_entry;
   logic [OFF-1:0]         lk_bridx;
   logic [31:0]            lk_target;
   logic                   lk_jump;
   logic [BI-1:0]          lk_index;
   logic [1:0]             lk_counter;
   logic                   lk_taken;
   logic [OFF-1:0]         lk_last;
   logic [FETCH_WIDTH-1:0] lk_mask;

   // Pick the earliest branch at or after the start lane; strict compare keeps the lowest entry on ties
   always_comb begin
      lk_hit    = 1'b0;
      lk_entry  = '0;
      lk_bridx  = '1;
      lk_target = '0;
      lk_jump   = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (e_valid[i] && (e_tag[i] == req_blk) && (e_bridx[i] >= req_lane)) begin
            if (!lk_hit || (e_bridx[i] < lk_bridx)) begin
               lk_hit    = 1'b1;
               lk_entry  = IDX'(i);
               lk_bridx  = e_bridx[i];
               lk_target = e_target[i];
               lk_jump   = e_jump[i];
            end
         end
      end
   end

   assign lk_index   = req_blk[BI-1:0] ^ BI'(ghr);
   assign lk_counter = bht[lk_index];
   assign lk_taken   = lk_hit && (lk_jump || lk_counter[1]);
   assign lk_last    = lk_taken ? lk_bridx : '1;

   // Lanes from the start lane up to the predicted branch (or block end) are live
   always_comb begin
      lk_mask = '0;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
         lk_mask[l] = (OFF'(l) >= req_lane) && (OFF'(l) <= lk_last);
      end
   end

   logic           upd_match;
   logic [IDX-1:0] upd_match_idx;
   logic [BI-1:0]  upd_index;
   logic [1:0]     upd_counter;

   // Find the entry already tracking this exact branch
   always_comb begin
      upd_match     = 1'b0;
      upd_match_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (e_valid[i] && (e_tag[i] == upd_blk) && (e_bridx[i] == upd_lane)) begin
            upd_match     = 1'b1;
            upd_match_idx = IDX'(i);
         end
      end
   end

   assign upd_index   = upd_blk[BI-1:0] ^ BI'(upd_history);
   assign upd_counter = bht[upd_index];

   // BTB training: refresh a matching entry or allocate round-robin on taken; invalidate overrides allocation
   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid   <= '0;
         alloc_ptr <= '0;
      end else begin
         if (upd_valid) begin
            if (upd_match) begin
               e_target[upd_match_idx] <= upd_target;
               e_jump[upd_match_idx]   <= upd_is_jump;
            end else if (upd_taken && !invalidate) begin
               e_valid[alloc_ptr]  <= 1'b1;
               e_tag[alloc_ptr]    <= upd_blk;
               e_bridx[alloc_ptr]  <= upd_lane;
               e_target[alloc_ptr] <= upd_target;
               e_jump[alloc_ptr]   <= upd_is_jump;
               alloc_ptr           <= alloc_ptr + IDX'(1);
            end
         end
         if (invalidate) begin
            e_valid <= '0;
         end
      end
   end

   // Conditional branches train the saturating counter and shift the outcome into global history
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
         ghr <= '0;
      end else if (upd_valid && !upd_is_jump) begin
         if (upd_taken) begin
            if (upd_counter != 2'b11) bht[upd_index] <= upd_counter + 2'b01;
         end else begin
            if (upd_counter != 2'b00) bht[upd_index] <= upd_counter - 2'b01;
         end
         ghr <= {ghr[HIST_BITS-2:0], upd_taken};
      end
   end

   // Register the prediction; idle cycles and reset force every output to zero
   always_ff @(posedge clk) begin
      if (reset || !req_valid) begin
         resp_valid   <= 1'b0;
         resp_hit     <= 1'b0;
         resp_taken   <= 1'b0;
         resp_mask    <= '0;
         resp_bridx   <= '0;
         resp_target  <= '0;
         resp_entry   <= '0;
         resp_history <= '0;
         resp_counter <= '0;
      end else begin
         resp_valid   <= 1'b1;
         resp_hit     <= lk_hit;
         resp_taken   <= lk_taken;
         resp_mask    <= lk_mask;
         resp_bridx   <= lk_bridx;
         resp_target  <= lk_target;
         resp_entry   <= lk_entry;
         resp_history <= ghr;
         resp_counter <= lk_counter;
      end
   end

endmodule

// File: tb/tb_btb_bht_predictor.sv
// tb/tb_btb_bht_predictor.sv - scoreboard bench for btb_bht_predictor against a behavioural model
module tb_btb_bht_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_hit;
   logic        resp_taken;
   logic [3:0]  resp_mask;
   logic [1:0]  resp_bridx;
   logic [31:0] resp_target;
   logic [2:0]  resp_entry;
   logic [5:0]  resp_history;
   logic [1:0]  resp_counter;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;
   logic [5:0]  upd_history;
   logic        invalidate;

   btb_bht_predictor dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .resp_valid   (resp_valid),
      .resp_hit     (resp_hit),
      .resp_taken   (resp_taken),
      .resp_mask    (resp_mask),
      .resp_bridx   (resp_bridx),
      .resp_target  (resp_target),
      .resp_entry   (resp_entry),
      .resp_history (resp_history),
      .resp_counter (resp_counter),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_target   (upd_target),
      .upd_taken    (upd_taken),
      .upd_is_jump  (upd_is_jump),
      .upd_history  (upd_history),
      .invalidate   (invalidate)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [3:0]  mask;
      logic [1:0]  bridx;
      logic [31:0] target;
      logic [2:0]  entry;
      logic [5:0]  hist;
      logic [1:0]  ctr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: list of branches keyed by (block, lane) plus a counter table and history value
   bit          m_valid [8];
   int unsigned m_blk   [8];
   int          m_lane  [8];
   int unsigned m_tgt   [8];
   bit          m_jmp   [8];
   int          m_bht   [64];
   int          m_ghr;
   int          m_ptr;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_ghr = 0;
      m_ptr = 0;
   endfunction

   function automatic exp_t model_lookup(logic [31:0] a);
      exp_t        r;
      int unsigned blk  = a >> 4;
      int          lane = int'((a >> 2) & 3);
      int          best = -1;
      int          ctr;
      int          last;
      int          mask = 0;
      for (int i = 0; i < 8; i++)
         if (m_valid[i] && m_blk[i] == blk && m_lane[i] >= lane)
            if (best < 0 || m_lane[i] < m_lane[best]) best = i;
      ctr      = m_bht[int'(blk % 64) ^ m_ghr];
      r.hit    = (best >= 0);
      r.taken  = (best >= 0) && (m_jmp[best < 0 ? 0 : best] || ctr >= 2);
      last     = r.taken ? m_lane[best] : 3;
      for (int l = lane; l <= last; l++) mask = mask + (1 << l);
      r.mask   = 4'(mask);
      r.bridx  = r.hit ? 2'(m_lane[best]) : 2'd3;
      r.target = r.hit ? m_tgt[best] : 32'd0;
      r.entry  = r.hit ? 3'(best) : 3'd0;
      r.hist   = 6'(m_ghr);
      r.ctr    = 2'(ctr);
      return r;
   endfunction

   function automatic void model_update(logic uv, logic [31:0] pc, logic [31:0] tgt, logic tk,
                                        logic jmp, logic [5:0] hist, logic inv);
      int unsigned blk  = pc >> 4;
      int          lane = int'((pc >> 2) & 3);
      int          match = -1;
      int          idx;
      if (uv) begin
         for (int i = 0; i < 8; i++)
            if (m_valid[i] && m_blk[i] == blk && m_lane[i] == lane) match = i;
         if (match >= 0) begin
            m_tgt[match] = tgt;
            m_jmp[match] = jmp;
         end else if (tk && !inv) begin
            m_valid[m_ptr] = 1;
            m_blk[m_ptr]   = blk;
            m_lane[m_ptr]  = lane;
            m_tgt[m_ptr]   = tgt;
            m_jmp[m_ptr]   = jmp;
            m_ptr          = (m_ptr + 1) % 8;
         end
         if (!jmp) begin
            idx = int'(blk % 64) ^ int'(hist);
            if (tk) begin
               if (m_bht[idx] < 3) m_bht[idx]++;
            end else begin
               if (m_bht[idx] > 0) m_bht[idx]--;
            end
            m_ghr = ((m_ghr << 1) | int'(tk)) % 64;
         end
      end
      if (inv) for (int i = 0; i < 8; i++) m_valid[i] = 0;
   endfunction

   task automatic step(input logic rv, input logic [31:0] ra, input logic uv, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk, input logic jmp, input logic [5:0] hist,
                       input logic inv);
      @(posedge clk);
      #1;
      req_valid   = rv;
      req_addr    = ra;
      upd_valid   = uv;
      upd_pc      = pc;
      upd_target  = tgt;
      upd_taken   = tk;
      upd_is_jump = jmp;
      upd_history = hist;
      invalidate  = inv;
      if (rv) exp_q.push_back(model_lookup(ra));
      model_update(uv, pc, tgt, tk, jmp, hist, inv);
   endtask

   task automatic lookup(input logic [31:0] a);
      step(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic jmp, input logic [5:0] hist);
      step(1'b0, 32'd0, 1'b1, pc, tgt, tk, jmp, hist, 1'b0);
   endtask

   // Monitor: every valid response is matched against the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("resp_hit",     64'(resp_hit),     64'(e.hit));
            chk("resp_taken",   64'(resp_taken),   64'(e.taken));
            chk("resp_mask",    64'(resp_mask),    64'(e.mask));
            chk("resp_bridx",   64'(resp_bridx),   64'(e.bridx));
            chk("resp_target",  64'(resp_target),  64'(e.target));
            chk("resp_entry",   64'(resp_entry),   64'(e.entry));
            chk("resp_history", 64'(resp_history), 64'(e.hist));
            chk("resp_counter", 64'(resp_counter), 64'(e.ctr));
         end
      end else if (reset === 1'b0) begin
         chk("idle_outputs_zero",
             64'({resp_hit, resp_taken, resp_mask, resp_bridx, resp_target,
                  resp_entry, resp_history, resp_counter}), 64'd0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, p;
      logic [5:0]  h;
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; upd_valid = 1'b0; upd_pc = '0;
      upd_target = '0; upd_taken = 1'b0; upd_is_jump = 1'b0; upd_history = '0; invalidate = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_resp_valid", 64'(resp_valid), 64'd0);
      chk("reset_resp_fields",
          64'({resp_hit, resp_taken, resp_mask, resp_bridx, resp_target,
               resp_entry, resp_history, resp_counter}), 64'd0);
      reset = 1'b0;

      // Cold miss, jump training, start-lane filtering
      lookup(32'h1000);
      update(32'h1004, 32'h2000, 1'b1, 1'b1, 6'd0);
      lookup(32'h1000);
      lookup(32'h1008);
      lookup(32'h1004);

      // Conditional branch counter saturation and history shifting
      repeat (3) update(32'h3000, 32'h3400, 1'b1, 1'b0, 6'd0);
      lookup(32'h3000);
      lookup(32'h3070);
      update(32'h3000, 32'h3400, 1'b0, 1'b0, 6'd7);
      lookup(32'h3000);

      // Reset with a request in the same cycle drops that response
      @(posedge clk);
      #1;
      reset = 1'b1; req_valid = 1'b1; req_addr = 32'h1000; upd_valid = 1'b0; invalidate = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("reset_drops_resp", 64'(resp_valid), 64'd0);

      // Nine allocations wrap the round-robin pointer back to entry 0
      for (int k = 0; k < 9; k++) update(32'h4000 + 32'(k) * 32'h10, 32'h8000 + 32'(k) * 4, 1'b1, 1'b1, 6'd0);
      lookup(32'h4000);
      lookup(32'h4080);
      lookup(32'h4010);

      // Invalidate beats a simultaneous allocating update
      step(1'b1, 32'h4080, 1'b1, 32'h5000, 32'h9000, 1'b1, 1'b1, 6'd0, 1'b1);
      lookup(32'h4080);
      lookup(32'h5000);
      update(32'h6008, 32'hA000, 1'b1, 1'b1, 6'd0);
      lookup(32'h6000);

      // Randomised traffic over a small set of blocks so hits, ties and retraining occur
      for (int n = 0; n < 600; n++) begin
         a = 32'h1000 + (32'($urandom_range(0, 3)) << 4) + (32'($urandom_range(0, 3)) << 2);
         p = 32'h1000 + (32'($urandom_range(0, 3)) << 4) + (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 9) == 0) a = $urandom & 32'hFFFF_FFFC;
         h = ($urandom_range(0, 1) == 1) ? 6'(m_ghr) : 6'($urandom_range(0, 63));
         step(1'($urandom_range(0, 3) != 0), a,
              1'($urandom_range(0, 1)), p, $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), h,
              1'($urandom_range(0, 39) == 0));
      end

      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
